// File: rtl/serial_ram_reader_pkg.sv
// Shared constants for the nibble-serial external RAM link.
// Holds the default pin counts and frame length, the derived word widths,
// a phase-counter width helper and the default round-trip delay that both
// the reader and any RAM model must agree on.
package serial_ram_pkg;

    localparam int DEF_ADDR_PINS   = 4;
    localparam int DEF_DATA_PINS   = 4;
    localparam int DEF_LOG2_CYCLES = 2;

    localparam int CYCLES    = 1 << DEF_LOG2_CYCLES;
    localparam int ADDR_BITS = DEF_ADDR_PINS * CYCLES;
    localparam int DATA_BITS = DEF_DATA_PINS * CYCLES;

    // Cycles from the end of an address frame to the first returned nibble.
    localparam int DEFAULT_RESP_DELAY = 8;

    // A one-cycle frame still needs a 1-bit phase register.
    function automatic int phase_width(input int log2_cycles);
        return (log2_cycles < 1) ? 1 : log2_cycles;
    endfunction

endpackage

// File: rtl/serial_ram_reader_if.sv
// Request/response and pin bundle for serial_ram_reader.
// master: the reader (accepts requests, drives address pins, returns words).
// slave : the requester plus RAM side.
// Signals: req_valid/req_ready/req_addr, addr_out, data_in,
//          resp_valid/resp_data, phase.
interface serial_ram_reader_if #(
    parameter int ADDR_PINS   = serial_ram_pkg::DEF_ADDR_PINS,
    parameter int DATA_PINS   = serial_ram_pkg::DEF_DATA_PINS,
    parameter int LOG2_CYCLES = serial_ram_pkg::DEF_LOG2_CYCLES
);
    localparam int N_CYC = 1 << LOG2_CYCLES;
    localparam int PW    = serial_ram_pkg::phase_width(LOG2_CYCLES);

    logic                         req_valid;
    logic                         req_ready;
    logic [ADDR_PINS*N_CYC-1:0]   req_addr;
    logic [ADDR_PINS-1:0]         addr_out;
    logic [DATA_PINS-1:0]         data_in;
    logic                         resp_valid;
    logic [DATA_PINS*N_CYC-1:0]   resp_data;
    logic [PW-1:0]                phase;

    modport master (
        input  req_valid, req_addr, data_in,
        output req_ready, addr_out, resp_valid, resp_data, phase
    );

    modport slave (
        output req_valid, req_addr, data_in,
        input  req_ready, addr_out, resp_valid, resp_data, phase
    );

endinterface

// File: rtl/serial_ram_reader_deser.sv
// serial_ram_deser: assembles CYCLES data nibbles (LSB first) into a word.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : this cycle carries nibble 0 of a capture window
//   issue       : the window belongs to an accepted request
//   data_in     : serial data pins
//   word_valid  : one-cycle pulse after the last nibble of an issued window
//   word_data   : assembled word, held until the next issued window ends
module serial_ram_deser
    import serial_ram_pkg::*;
#(
    parameter int DATA_PINS   = DEF_DATA_PINS,
    parameter int LOG2_CYCLES = DEF_LOG2_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       issue,
    input  logic [DATA_PINS-1:0]       data_in,
    output logic                       word_valid,
    output logic [DATA_PINS*(1<<LOG2_CYCLES)-1:0] word_data
);
    localparam int N_CYC  = 1 << LOG2_CYCLES;
    localparam int D_BITS = DATA_PINS * N_CYC;
    localparam int PW     = phase_width(LOG2_CYCLES);

    // Only the nibbles captured so far need storing; the current one comes
    // straight from the pins.
    logic [D_BITS-DATA_PINS-1:0] acc_q;
    logic [PW-1:0]               left_q;
    logic                        active_q;
    logic                        issue_q;

    logic                        cap;
    logic                        last;
    logic                        issue_now;
    logic [PW-1:0]               left_now;
    logic [D_BITS-1:0]           shifted;

    always_comb begin
        cap       = start | active_q;
        left_now  = start ? PW'(N_CYC - 1) : left_q;
        issue_now = start ? issue : issue_q;
        last      = cap && (left_now == '0);
        shifted   = {data_in, acc_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            left_q     <= '0;
            active_q   <= 1'b0;
            issue_q    <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= last & issue_now;
            if (cap) begin
                acc_q    <= shifted[D_BITS-1:DATA_PINS];
                left_q   <= left_now - PW'(1);
                issue_q  <= issue_now;
                active_q <= !last;
            end
            if (last && issue_now) begin
                word_data <= shifted;
            end
        end
    end

endmodule

// File: rtl/serial_ram_reader.sv
// serial_ram_reader: initiator side of the nibble-serial external RAM link.
// Serializes one read address per frame of 2**LOG2_CYCLES cycles, samples
// the returned nibbles after a fixed round trip, and pulses each word out.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : serial_ram_reader_if.master (request, pins, response, phase)
// Build option: define SERIAL_RAM_READER_RESP_REG_EN to add one register
// stage on resp_valid/resp_data (response one cycle later).
module serial_ram_reader
    import serial_ram_pkg::*;
#(
    parameter int ADDR_PINS   = DEF_ADDR_PINS,
    parameter int DATA_PINS   = DEF_DATA_PINS,
    parameter int LOG2_CYCLES = DEF_LOG2_CYCLES,
    parameter int RESP_DELAY  = DEFAULT_RESP_DELAY
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_ram_reader_if.master  bus
);
    localparam int N_CYC  = 1 << LOG2_CYCLES;
    localparam int A_BITS = ADDR_PINS * N_CYC;
    localparam int D_BITS = DATA_PINS * N_CYC;
    localparam int PW     = phase_width(LOG2_CYCLES);
    localparam int DEPTH  = N_CYC + RESP_DELAY;
    localparam logic [PW-1:0] LAST_PHASE = PW'(N_CYC - 1);

    logic [PW-1:0]     phase_q;
    logic [A_BITS-1:0] addr_q;
    logic              frame_issued_q;
    logic [DEPTH-1:0]  start_sr;
    logic [DEPTH-1:0]  issue_sr;

    logic              ready;
    logic              accept;
    logic              word_valid;
    logic [D_BITS-1:0] word_data;

    assign ready  = (phase_q == LAST_PHASE) && !reset;
    assign accept = bus.req_valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q        <= '0;
            addr_q         <= '0;
            frame_issued_q <= 1'b0;
            start_sr       <= '0;
            issue_sr       <= '0;
        end else begin
            // Power-of-two frame length, so the counter wraps on its own.
            phase_q <= phase_q + PW'(1);
            if (accept) begin
                addr_q <= bus.req_addr;
            end
            if (phase_q == LAST_PHASE) begin
                frame_issued_q <= accept;
            end
            // One token per cycle; a token marks a frame start (phase 0) and
            // whether that frame carries a real request. It surfaces exactly
            // when that frame's first data nibble is on the pins.
            start_sr <= {start_sr[DEPTH-2:0], phase_q == '0};
            issue_sr <= {issue_sr[DEPTH-2:0], frame_issued_q && (phase_q == '0)};
        end
    end

    serial_ram_deser #(
        .DATA_PINS   (DATA_PINS),
        .LOG2_CYCLES (LOG2_CYCLES)
    ) u_deser (
        .clk        (clk),
        .reset      (reset),
        .start      (start_sr[DEPTH-1]),
        .issue      (issue_sr[DEPTH-1]),
        .data_in    (bus.data_in),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    assign bus.req_ready = ready;
    assign bus.phase     = phase_q;
    assign bus.addr_out  = addr_q[int'(phase_q)*ADDR_PINS +: ADDR_PINS];

`ifdef SERIAL_RAM_READER_RESP_REG_EN
    logic              resp_valid_q;
    logic [D_BITS-1:0] resp_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= word_valid;
            resp_data_q  <= word_data;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
`else
    assign bus.resp_valid = word_valid;
    assign bus.resp_data  = word_data;
`endif

endmodule

// File: tb/tb_serial_ram_reader.sv
// Testbench for serial_ram_reader. A behavioural RAM watches the address
// pins frame by frame and schedules each word's nibbles onto data_in a fixed
// number of cycles later; expected responses come from accept cycles plus
// the documented round-trip latency.
module tb_serial_ram_reader;
    import serial_ram_pkg::*;

    localparam int C  = CYCLES;
    localparam int RD = DEFAULT_RESP_DELAY;
`ifdef SERIAL_RAM_READER_RESP_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    // Cycles from nibble 0 of an address frame to resp_valid.
    localparam int LAT = C + RD + C + EXTRA;

    typedef struct {
        int          c;
        logic [15:0] d;
    } resp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_ram_reader_if bus ();

    serial_ram_reader #(.RESP_DELAY(RD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ph_model = 0;
    resp_t exp_q[$];
    resp_t obs_q[$];

    bit [3:0]  sched_d[64];
    bit        sched_v[64];
    logic [15:0] ram_acc = '0;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        logic [15:0] h;
        if (a == 16'h1234) return 16'hA5C3;
        h = a * 16'h9E37;
        return h ^ 16'h3C5A ^ {a[7:0], a[15:8]};
    endfunction

    // Cycle counter and the RAM's own frame counter (shares reset).
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        ph_model <= reset ? 0 : (ph_model + 1) % C;
    end

    // RAM model: drive this cycle's data nibble, collect the address chunk.
    always @(negedge clk) begin
        int s, t0, idx;
        logic [15:0] w;
        s = cyc % 64;
        if (sched_v[s]) begin
            bus.data_in = sched_d[s];
            sched_v[s]  = 1'b0;
        end else begin
            bus.data_in = 4'($urandom);
        end
        ram_acc[ph_model*4 +: 4] = bus.addr_out;
        if (ph_model == C - 1) begin
            w  = mem_rd(ram_acc);
            t0 = cyc - (C - 1);
            for (int j = 0; j < C; j++) begin
                idx = (t0 + C + RD + j) % 64;
                sched_d[idx] = w[4*j +: 4];
                sched_v[idx] = 1'b1;
            end
        end
    end

    // Response logger.
    always @(negedge clk) begin
        resp_t r;
        if (bus.resp_valid === 1'b1) begin
            r.c = cyc;
            r.d = bus.resp_data;
            obs_q.push_back(r);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_read(input logic [15:0] a, output bit ok, output int acc);
        resp_t r;
        ok  = 1'b0;
        acc = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        for (int i = 0; i < 2*C && !ok; i++) begin
            if (bus.req_ready === 1'b1) begin
                ok  = 1'b1;
                acc = cyc;
                r.c = acc + 1 + LAT;
                r.d = mem_rd(a);
                exp_q.push_back(r);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
        checks++; if (bus.resp_data !== 16'h0) begin errors++; $display("FAIL reset_resp_data got %h want 0000", bus.resp_data); end
        checks++; if (bus.addr_out !== 4'h0) begin errors++; $display("FAIL reset_addr_out got %h want 0", bus.addr_out); end
        checks++; if (bus.phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", bus.phase); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
        reset = 1'b0;
        repeat (C) @(negedge clk);
        checks++; if (bus.phase !== 2'(ph_model)) begin errors++; $display("FAIL phase_run got %0d want %0d", bus.phase, ph_model); end
    endtask

    task automatic test_single;
        bit ok; int acc;
        exp_q.delete(); obs_q.delete();
        do_read(16'h1234, ok, acc);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept got none want accept"); end
        for (int k = 0; k < C; k++) begin
            logic [15:0] a;
            a = 16'h1234;
            checks++;
            if (bus.addr_out !== a[4*k +: 4]) begin
                errors++; $display("FAIL single_addr_nib%0d got %h want %h", k, bus.addr_out, a[4*k +: 4]);
            end
            @(negedge clk);
        end
        wait_cycle(acc + 1 + LAT + C);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            checks++; if (obs_q[0].c != acc + 1 + LAT) begin errors++; $display("FAIL single_latency got cycle %0d want %0d", obs_q[0].c, acc + 1 + LAT); end
            checks++; if (obs_q[0].d !== 16'hA5C3) begin errors++; $display("FAIL single_data got %h want a5c3", obs_q[0].d); end
        end
        checks++; if (bus.resp_data !== 16'hA5C3) begin errors++; $display("FAIL single_hold got %h want a5c3", bus.resp_data); end
    endtask

    task automatic test_back_to_back;
        bit ok; int acc;
        exp_q.delete(); obs_q.delete();
        for (int i = 1; i <= 3; i++) begin
            do_read(16'(i), ok, acc);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_accept%0d got none want accept", i); end
        end
        wait_cycle(acc + 1 + LAT + C);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i].c != exp_q[i].c) begin errors++; $display("FAIL b2b_cycle%0d got %0d want %0d", i, obs_q[i].c, exp_q[i].c); end
            checks++; if (obs_q[i].d !== exp_q[i].d) begin errors++; $display("FAIL b2b_data%0d got %h want %h", i, obs_q[i].d, exp_q[i].d); end
        end
        if (obs_q.size() == 3) begin
            checks++; if (obs_q[2].c - obs_q[0].c != 2*C) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", obs_q[2].c - obs_q[0].c, 2*C); end
        end
    endtask

    task automatic test_idle;
        bit ok; int acc;
        logic [15:0] a;
        exp_q.delete(); obs_q.delete();
        a = 16'($urandom);
        do_read(a, ok, acc);
        checks++; if (!ok) begin errors++; $display("FAIL idle_accept got none want accept"); end
        for (int i = 0; i < 10*C; i++) begin
            checks++;
            if (bus.addr_out !== a[4*ph_model +: 4]) begin
                errors++; $display("FAIL idle_addr cyc %0d got %h want %h", cyc, bus.addr_out, a[4*ph_model +: 4]);
            end
            @(negedge clk);
        end
        wait_cycle(acc + 1 + LAT + 2*C);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL idle_count got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            checks++; if (obs_q[0].d !== exp_q[0].d) begin errors++; $display("FAIL idle_data got %h want %h", obs_q[0].d, exp_q[0].d); end
        end
    endtask

    task automatic test_not_ready;
        int accepts;
        int acc;
        resp_t r;
        logic [15:0] a;
        exp_q.delete(); obs_q.delete();
        accepts = 0; acc = 0;
        a = 16'($urandom);
        while (ph_model != 1) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        for (int i = 0; i < 2*C; i++) begin
            checks++;
            if (bus.req_ready !== (ph_model == C - 1)) begin
                errors++; $display("FAIL not_ready_phase%0d got %b want %b", ph_model, bus.req_ready, ph_model == C - 1);
            end
            if (bus.req_valid && bus.req_ready === 1'b1) begin
                accepts++;
                acc = cyc;
                r.c = acc + 1 + LAT;
                r.d = mem_rd(a);
                exp_q.push_back(r);
                @(negedge clk);
                bus.req_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        bus.req_valid = 1'b0;
        checks++; if (accepts != 1) begin errors++; $display("FAIL not_ready_accepts got %0d want 1", accepts); end
        wait_cycle(acc + 1 + LAT + C);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL not_ready_count got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            checks++; if (obs_q[0].c != acc + 1 + LAT || obs_q[0].d !== mem_rd(a)) begin
                errors++; $display("FAIL not_ready_resp got %h@%0d want %h@%0d", obs_q[0].d, obs_q[0].c, mem_rd(a), acc + 1 + LAT);
            end
        end
    endtask

    task automatic test_reset_midflight;
        bit ok; int acc;
        logic [15:0] a;
        exp_q.delete(); obs_q.delete();
        do_read(16'($urandom), ok, acc);
        do_read(16'($urandom), ok, acc);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++; if (bus.phase !== 2'd0) begin errors++; $display("FAIL midreset_phase got %0d want 0", bus.phase); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b want 0", bus.req_ready); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.phase !== 2'd1) begin errors++; $display("FAIL midreset_restart got %0d want 1", bus.phase); end
        wait_cycle(acc + 1 + LAT + 2*C);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midreset_dropped got %0d responses want 0", obs_q.size()); end
        obs_q.delete();
        a = 16'($urandom);
        do_read(a, ok, acc);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_accept got none want accept"); end
        wait_cycle(acc + 1 + LAT + C);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL midreset_count got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            checks++; if (obs_q[0].c != acc + 1 + LAT || obs_q[0].d !== mem_rd(a)) begin
                errors++; $display("FAIL midreset_resp got %h@%0d want %h@%0d", obs_q[0].d, obs_q[0].c, mem_rd(a), acc + 1 + LAT);
            end
        end
    endtask

    task automatic test_random;
        bit ok; int acc;
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 16; i++) begin
            repeat (C * $urandom_range(0, 2)) @(negedge clk);
            do_read(16'($urandom), ok, acc);
            checks++; if (!ok) begin errors++; $display("FAIL rand_accept%0d got none want accept", i); end
        end
        wait_cycle(acc + 1 + LAT + C);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i].c != exp_q[i].c || obs_q[i].d !== exp_q[i].d) begin
                errors++; $display("FAIL rand_resp%0d got %h@%0d want %h@%0d", i, obs_q[i].d, obs_q[i].c, exp_q[i].d, exp_q[i].c);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        repeat (3) @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_idle;
        test_not_ready;
        test_reset_midflight;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
